// File: rtl/au_seq.sv
// ============================================================================
// au_seq : handshaked W-bit arithmetic unit with registered results,
//          shift-add unsigned multiply, accumulator and sticky overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module au_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         ov,
   output logic         gt,
   output logic         lt,
   output logic         eq,
   output logic         ov_sticky
);

   localparam int CW = $clog2(W + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [2:0] OP_ADDU   = 3'b000;
   localparam logic [2:0] OP_SUBU   = 3'b001;
   localparam logic [2:0] OP_ADDS   = 3'b010;
   localparam logic [2:0] OP_SUBS   = 3'b011;
   localparam logic [2:0] OP_MULU   = 3'b100;
   localparam logic [2:0] OP_ACC    = 3'b101;
   localparam logic [2:0] OP_CLRACC = 3'b110;

   logic [1:0]     state_q, state_d;
   logic [W-1:0]   y_q, y_d;
   logic           ov_q, ov_d;
   logic           gt_q, gt_d;
   logic           lt_q, lt_d;
   logic           eq_q, eq_d;
   logic           sticky_q, sticky_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic           accept;
   logic           mul_last;
   logic [W:0]     w_add, w_sub, w_acc;
   logic [2*W-1:0] w_prod_nx;
   logic [W-1:0]   res_y;
   logic           res_ov, res_gt, res_lt, res_eq;

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         y_q      <= '0;
         ov_q     <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
         eq_q     <= 1'b0;
         sticky_q <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         ov_q     <= ov_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
         sticky_q <= sticky_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = (op == OP_MULU) ? S_MUL : S_HOLD;
         end
         S_MUL: begin
            if (mul_last) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (accept)         state_d = (op == OP_MULU) ? S_MUL : S_HOLD;
            else if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
      out_valid = (state_q == S_HOLD);
      y         = y_q;
      ov        = ov_q;
      gt        = gt_q;
      lt        = lt_q;
      eq        = eq_q;
      ov_sticky = sticky_q;
   end

   assign accept   = in_valid & in_ready;
   assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(W - 1));

   // ---------------------------------------------------------------- single-cycle ops
   always_comb begin
      w_add  = {1'b0, a} + {1'b0, b};
      w_sub  = {1'b0, a} - {1'b0, b};
      w_acc  = {1'b0, acc_q} + {1'b0, a};
      res_y  = '0;
      res_ov = 1'b0;
      res_gt = (a > b);
      res_lt = (a < b);
      res_eq = (a == b);
      case (op)
         OP_ADDU: begin
            res_y  = w_add[W-1:0];
            res_ov = w_add[W];
         end
         OP_SUBU: begin
            res_y  = w_sub[W-1:0];
            res_ov = w_sub[W];
         end
         OP_ADDS: begin
            res_y  = w_add[W-1:0];
            res_ov = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
            res_gt = ($signed(a) > $signed(b));
            res_lt = ($signed(a) < $signed(b));
         end
         OP_SUBS: begin
            res_y  = w_sub[W-1:0];
            res_ov = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
            res_gt = ($signed(a) > $signed(b));
            res_lt = ($signed(a) < $signed(b));
         end
         OP_ACC: begin
            res_y  = w_acc[W-1:0];
            res_ov = w_acc[W];
         end
         OP_CLRACC: begin
            res_y  = '0;
            res_ov = 1'b0;
         end
         OP_MULU: begin
            res_y  = '0;
            res_ov = 1'b0;
         end
         default: begin
            res_gt = 1'b0;
            res_lt = 1'b0;
            res_eq = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath next values
   always_comb begin
      w_prod_nx = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
      y_d      = y_q;
      ov_d     = ov_q;
      gt_d     = gt_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      sticky_d = sticky_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (accept) begin
         gt_d = res_gt;
         lt_d = res_lt;
         eq_d = res_eq;
         if (op == OP_MULU) begin
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
         end else begin
            y_d  = res_y;
            ov_d = res_ov;
            if (op == OP_ACC)    acc_d = w_acc[W-1:0];
            if (op == OP_CLRACC) acc_d = '0;
            sticky_d = (op == OP_CLRACC) ? 1'b0 : (sticky_q | res_ov);
         end
      end else if (state_q == S_MUL) begin
         // One shift-add step per cycle; the last step lands the result in HOLD.
         prod_d   = w_prod_nx;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (mul_last) begin
            y_d      = w_prod_nx[W-1:0];
            ov_d     = |w_prod_nx[2*W-1:W];
            sticky_d = sticky_q | (|w_prod_nx[2*W-1:W]);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_au_seq.sv
// ============================================================================
// tb_au_seq : randomized and directed checks of au_seq (W=3 and W=8) against
//             an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_au_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] iv;
   logic [1:0] ordy;
   logic [7:0] ia  [2];
   logic [7:0] ib  [2];
   logic [2:0] iop [2];
   wire  [1:0] ir, ovld, ovf, gtv, ltv, eqv, stk;
   wire  [2:0] y3;
   wire  [7:0] y8;

   int npass  = 0;
   int ntotal = 0;

   longint acc_m [2];
   bit     stk_m [2];
   longint ey;
   bit     eov, egt, elt, eeq;

   always #5 clk = ~clk;

   au_seq #(.W(3)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(ia[0][2:0]), .b(ib[0][2:0]), .op(iop[0]),
      .out_valid(ovld[0]), .out_ready(ordy[0]), .y(y3), .ov(ovf[0]),
      .gt(gtv[0]), .lt(ltv[0]), .eq(eqv[0]), .ov_sticky(stk[0])
   );

   au_seq #(.W(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(ia[1]), .b(ib[1]), .op(iop[1]),
      .out_valid(ovld[1]), .out_ready(ordy[1]), .y(y8), .ov(ovf[1]),
      .gt(gtv[1]), .lt(ltv[1]), .eq(eqv[1]), .ov_sticky(stk[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Arithmetic meaning of each op, using wide integers instead of bit tricks.
   function automatic void model(input int w, input logic [2:0] op, input longint a,
                                 input longint b, inout longint acc, output longint y,
                                 output bit ov, output bit gt, output bit lt,
                                 output bit eq, output bit clr);
      longint m, h, sa, sb, r;
      m  = longint'(1) << w;
      h  = m / 2;
      sa = (a >= h) ? a - m : a;
      sb = (b >= h) ? b - m : b;
      gt = (a > b); lt = (a < b); eq = (a == b);
      ov = 1'b0; clr = 1'b0; y = 0;
      case (op)
         3'd0: begin r = a + b; ov = (r >= m); y = r % m; end
         3'd1: begin r = a - b; ov = (r < 0); y = (r + m) % m; end
         3'd2: begin r = sa + sb; ov = (r < -h) || (r >= h); y = ((r % m) + m) % m;
                     gt = (sa > sb); lt = (sa < sb); end
         3'd3: begin r = sa - sb; ov = (r < -h) || (r >= h); y = ((r % m) + m) % m;
                     gt = (sa > sb); lt = (sa < sb); end
         3'd4: begin r = a * b; ov = (r >= m); y = r % m; end
         3'd5: begin r = acc + a; ov = (r >= m); y = r % m; acc = y; end
         3'd6: begin acc = 0; clr = 1'b1; end
         default: begin gt = 1'b0; lt = 1'b0; eq = 1'b0; end
      endcase
   endfunction

   task automatic check_result(input int s);
      chk("y",      (s != 0) ? 64'(y8) : 64'(y3), 64'(ey));
      chk("ov",     64'(ovf[s]), 64'(eov));
      chk("gt",     64'(gtv[s]), 64'(egt));
      chk("lt",     64'(ltv[s]), 64'(elt));
      chk("eq",     64'(eqv[s]), 64'(eeq));
      chk("sticky", 64'(stk[s]), 64'(stk_m[s]));
   endtask

   task automatic run(input int s, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit rdy_after);
      int     w;
      int     n, k, lat;
      longint mask;
      bit     clr;
      w    = (s == 0) ? 3 : 8;
      mask = (longint'(1) << w) - 1;
      @(negedge clk);
      iv[s] = 1'b1; ia[s] = a; ib[s] = b; iop[s] = op; ordy[s] = 1'b1;
      #1;
      n = 0;
      while (!ir[s] && n < 100) begin
         @(negedge clk); #1; n++;
      end
      chk("accept_wait", 64'(n), 64'd0);
      model(w, op, longint'(a) & mask, longint'(b) & mask, acc_m[s], ey, eov, egt, elt, eeq, clr);
      stk_m[s] = clr ? 1'b0 : (stk_m[s] | eov);
      @(posedge clk); #1;
      iv[s] = 1'b0; ia[s] = 8'($urandom); ib[s] = 8'($urandom); iop[s] = 3'($urandom);
      ordy[s] = rdy_after;
      lat = (op == 3'd4) ? w + 1 : 1;
      k = 0;
      do begin
         @(negedge clk); k++;
         if (!ovld[s] && k < 40) chk("busy_ready", 64'(ir[s]), 64'd0);
      end while (!ovld[s] && k < 40);
      chk("latency", 64'(k), 64'(lat));
      check_result(s);
   endtask

   task automatic hold_check(input int s, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         iv[s] = 1'b1; ia[s] = 8'($urandom); ib[s] = 8'($urandom); iop[s] = 3'($urandom);
         @(negedge clk);
         chk("hold_valid", 64'(ovld[s]), 64'd1);
         chk("hold_ready", 64'(ir[s]), 64'd0);
         check_result(s);
      end
      iv[s] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; iv = '0; ordy = '0;
      for (int s = 0; s < 2; s++) begin
         ia[s] = '0; ib[s] = '0; iop[s] = '0; acc_m[s] = 0; stk_m[s] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_valid",  64'(ovld[s]), 64'd0);
         chk("rst_sticky", 64'(stk[s]),  64'd0);
         chk("rst_ready",  64'(ir[s]),   64'd1);
      end
      chk("rst_y3", 64'(y3), 64'd0);
      chk("rst_y8", 64'(y8), 64'd0);
      rst = 1'b0;

      run(0, 3'd0, 8'd5, 8'd5, 1'b1);
      @(negedge clk);
      chk("valid_drop", 64'(ovld[0]), 64'd0);
      run(0, 3'd3, 8'd3, 8'd5, 1'b1);
      run(0, 3'd1, 8'd3, 8'd5, 1'b1);
      run(0, 3'd4, 8'd5, 8'd3, 1'b1);
      run(0, 3'd0, 8'd2, 8'd3, 1'b0);
      hold_check(0, 5);
      run(0, 3'd2, 8'd3, 8'd1, 1'b1);
      run(0, 3'd6, 8'd0, 8'd0, 1'b1);
      run(0, 3'd5, 8'd4, 8'd0, 1'b1);
      run(0, 3'd5, 8'd5, 8'd0, 1'b1);
      run(0, 3'd0, 8'd2, 8'd2, 1'b1);
      run(0, 3'd6, 8'd0, 8'd0, 1'b1);
      run(0, 3'd7, 8'd6, 8'd1, 1'b1);

      // Abort a W=8 multiply mid-flight with rst while ov_sticky is set.
      run(1, 3'd0, 8'hFF, 8'hFF, 1'b1);
      @(negedge clk);
      iv[1] = 1'b1; ia[1] = 8'hFF; ib[1] = 8'h02; iop[1] = 3'd4; ordy[1] = 1'b1;
      #1;
      chk("mul_ready", 64'(ir[1]), 64'd1);
      @(posedge clk); #1;
      iv[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_valid",  64'(ovld[1]), 64'd0);
      chk("abort_y",      64'(y8),      64'd0);
      chk("abort_flags",  64'({ovf[1], gtv[1], ltv[1], eqv[1]}), 64'd0);
      chk("abort_sticky", 64'(stk[1]),  64'd0);
      chk("abort_sticky3", 64'(stk[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_ready", 64'(ir[1]), 64'd1);
      for (int s = 0; s < 2; s++) begin
         acc_m[s] = 0; stk_m[s] = 1'b0;
      end
      run(1, 3'd0, 8'h80, 8'h80, 1'b1);

      for (int i = 0; i < 200; i++) begin
         run(int'($urandom_range(1, 0)), 3'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(3, 0) != 0));
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

`default_nettype wire
